cl_read_issuer: RTL and testbench
=================================

CL_READ_ISSUER -- requirements
Module: cl_read_issuer

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 64, the maximum number of read requests in flight.
REQ-002 The block SHALL have parameter ADDR_VIRTUAL, default 1, the value passed as checkPermission/virtual flag when default MPF request-header params are built.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a one-cycle command strobe.
REQ-006 The block SHALL have port base_addr, input, t_byteAddr, the byte address of the first line.
REQ-007 The block SHALL have port num_lines, input, 32, the number of cache lines to read.
REQ-008 The block SHALL have port busy, output, 1, high from accepted start to done.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port error, output, 1, a one-cycle pulse on a rejected command.
REQ-011 The block SHALL have port c0TxAlmFull, input, 1, the MPF read-channel almost-full signal.
REQ-012 The block SHALL have port rd_req_valid, output, 1, the read-request valid.
REQ-013 The block SHALL have port rd_req_hdr, output, t_cci_mpf_c0_ReqMemHdr, the read-request header.
REQ-014 The block SHALL have port rd_rsp_valid, input, 1, a c0 read response valid.
REQ-015 The block SHALL have port rd_rsp_mdata, input, t_cci_mdata, the response metadata.
REQ-016 The block SHALL have port rd_rsp_data, input, CACHE_WIDTH, the response cache line.
REQ-017 The block SHALL have port out_valid, output, 1, the forwarded-line valid.
REQ-018 The block SHALL have port out_data, output, CACHE_WIDTH, the forwarded line.
REQ-019 The block SHALL have port out_idx, output, 16, the forwarded line index (equal to mdata).

Function
REQ-020 The block SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-021 IDLE SHALL transition on start: to IDLE with error=1 if base_addr[5:0]!=0; to DONE if num_lines==0; otherwise to ISSUE, latching byteAddrToClAddr(base_addr) and num_lines.
REQ-022 In ISSUE, rd_req_valid SHALL be asserted in a cycle only when c0TxAlmFull==0 and outstanding<MAX_OUTSTANDING.
REQ-023 Each request SHALL use hint eREQ_RDLINE_I, address base_cl+issued_count, mdata issued_count[15:0], single-line length, and cci_mpf_defaultReqHdrParams(ADDR_VIRTUAL).
REQ-024 rd_req_valid and rd_req_hdr SHALL be registered outputs.
REQ-025 ISSUE SHALL go to DRAIN in the cycle after the last request is issued.
REQ-026 DRAIN SHALL go to DONE when outstanding==0 and no response is arriving.
REQ-027 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-028 The outstanding counter SHALL increment on issue, decrement on rd_rsp_valid, and stay unchanged when both occur in the same cycle.
REQ-029 Each rd_rsp_valid SHALL produce out_valid exactly one cycle later, with out_data and out_idx taken from that response; responses SHALL be forwarded in arrival order with no reordering.
REQ-030 start SHALL be ignored while busy.
REQ-031 Address arithmetic SHALL wrap modulo 2^$bits(t_cci_clAddr).
REQ-032 issued_count SHALL be 32 bits wide; mdata SHALL carry the low 16 bits, so indices wrap for transfers longer than 65536 lines.
REQ-033 The outstanding counter SHALL be $clog2(MAX_OUTSTANDING+1) bits wide.

Reset
REQ-034 While reset_n==0 at a clk edge, the state SHALL become IDLE and all counters 0.
REQ-035 While reset_n==0, busy, done, error, rd_req_valid and out_valid SHALL be 0; headers and data are don't-care.
REQ-036 A reset during ISSUE or DRAIN SHALL abandon the command; late responses arriving after reset SHALL still be forwarded but SHALL NOT underflow the outstanding counter (saturate at 0).

Structure
REQ-037 t_byteAddr, byteAddrToClAddr, CACHE_WIDTH and rd_req_hdr_config_t SHALL come from package afu_base.
REQ-038 A new enum t_rd_issuer_state SHALL be added to afu_base.
REQ-039 The outstanding credit counter SHALL be the sub-module credit_counter, parameterised on MAX_OUTSTANDING.

Verification
REQ-040 base=0x1000, num_lines=4, almFull=0, immediate responses -> exactly 4 requests with cl addrs 0x40–0x43 and mdata 0–3, 4 out_valid, done once.
REQ-041 base=0x1004 -> error pulse for 1 cycle, no rd_req_valid, busy stays 0.
REQ-042 num_lines=0 -> done pulse 2 cycles after start, no requests.
REQ-043 MAX_OUTSTANDING=4, num_lines=10, responses withheld -> exactly 4 requests; releasing responses one per cycle -> remaining 6 issued; issue and response in the same cycle leave the count unchanged.
REQ-044 c0TxAlmFull held high for 5 cycles mid-transfer -> zero requests in those cycles, transfer completes with all indices present.
REQ-045 reset_n low for 1 cycle during DRAIN with 3 outstanding -> state IDLE, busy 0; the 3 late responses are forwarded on out_valid and the counter stays 0.

Source files
------------

// File: rtl/afu_base.sv
// Shared AFU types: CCI/MPF request header, cache-line addressing and the
// read-issuer state encoding.
package afu_base;

    localparam int CACHE_WIDTH = 512;
    localparam int CL_ADDR_W   = 42;
    localparam int BYTE_ADDR_W = CL_ADDR_W + 6;

    typedef logic [BYTE_ADDR_W-1:0] t_byteAddr;
    typedef logic [CL_ADDR_W-1:0]   t_cci_clAddr;
    typedef logic [15:0]            t_cci_mdata;
    typedef logic [CACHE_WIDTH-1:0] t_cci_clData;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_cci_c0_req;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'd0,
        eCL_LEN_2 = 2'd1,
        eCL_LEN_4 = 2'd3
    } t_cci_clLen;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_cci_vc;

    typedef struct packed {
        logic       checkLoadStoreOrder;
        logic       addrIsVirtual;
        logic       mapVAtoPA;
        t_cci_vc    vc_sel;
        t_cci_clLen cl_len;
    } rd_req_hdr_config_t;

    typedef struct packed {
        logic        checkLoadStoreOrder;
        logic        addrIsVirtual;
        logic        mapVAtoPA;
        t_cci_vc     vc_sel;
        t_cci_clLen  cl_len;
        t_cci_c0_req req_type;
        t_cci_clAddr address;
        t_cci_mdata  mdata;
    } t_cci_mpf_c0_ReqMemHdr;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_rd_issuer_state;

    function automatic t_cci_clAddr byteAddrToClAddr(input t_byteAddr a);
        return a[BYTE_ADDR_W-1:6];
    endfunction

    // The virtual flag doubles as the permission-check request to MPF.
    function automatic rd_req_hdr_config_t cci_mpf_defaultReqHdrParams(input logic addr_virtual);
        rd_req_hdr_config_t p;
        p.checkLoadStoreOrder = 1'b0;
        p.addrIsVirtual       = addr_virtual;
        p.mapVAtoPA           = addr_virtual;
        p.vc_sel              = eVC_VA;
        p.cl_len              = eCL_LEN_1;
        return p;
    endfunction

    function automatic t_cci_mpf_c0_ReqMemHdr cci_mpf_c0_genReqHdr(
        input t_cci_c0_req        req_type,
        input t_cci_clAddr        address,
        input t_cci_mdata         mdata,
        input rd_req_hdr_config_t params
    );
        t_cci_mpf_c0_ReqMemHdr h;
        h.checkLoadStoreOrder = params.checkLoadStoreOrder;
        h.addrIsVirtual       = params.addrIsVirtual;
        h.mapVAtoPA           = params.mapVAtoPA;
        h.vc_sel              = params.vc_sel;
        h.cl_len              = params.cl_len;
        h.req_type            = req_type;
        h.address             = address;
        h.mdata               = mdata;
        return h;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Outstanding-request counter: up on issue, down on response, saturating at
// zero so responses to an abandoned command cannot wrap it.
module credit_counter #(
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 i_inc,
    input  logic                                 i_dec,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_count,
    output logic                                 o_full,
    output logic                                 o_empty
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count >= MAX_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/cl_read_issuer.sv
// Streams single-line MPF reads for a contiguous cache-line range, bounded by
// an outstanding-request budget, and forwards responses in arrival order.
module cl_read_issuer
    import afu_base::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_VIRTUAL    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  t_byteAddr              base_addr,
    input  logic [31:0]            num_lines,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    input  logic                   c0TxAlmFull,
    output logic                   rd_req_valid,
    output t_cci_mpf_c0_ReqMemHdr  rd_req_hdr,
    input  logic                   rd_rsp_valid,
    input  t_cci_mdata             rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    output logic                   out_valid,
    output logic [CACHE_WIDTH-1:0] out_data,
    output logic [15:0]            out_idx
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    t_rd_issuer_state      r_state;
    t_cci_clAddr           r_base_cl;
    logic [31:0]           r_num_lines;
    logic [31:0]           r_issued;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_req_valid;
    t_cci_mpf_c0_ReqMemHdr r_req_hdr;
    logic                  r_out_valid;
    logic [CACHE_WIDTH-1:0] r_out_data;
    logic [15:0]           r_out_idx;

    logic [CNT_W-1:0]      w_outstanding;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_issue;
    logic                  w_last;
    rd_req_hdr_config_t    w_params;

    assign w_params = cci_mpf_defaultReqHdrParams(ADDR_VIRTUAL != 0);
    assign w_issue  = (r_state == ST_ISSUE) && (r_issued != r_num_lines) &&
                      !c0TxAlmFull && !w_full;
    assign w_last   = ((r_issued + 32'd1) == r_num_lines);

    // Credit is taken when the issue decision is made, one cycle before the
    // request becomes visible, so the budget can never be overshot.
    credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_issue),
        .i_dec   (rd_rsp_valid),
        .o_count (w_outstanding),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_base_cl   <= '0;
            r_num_lines <= '0;
            r_issued    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_req_valid <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_req_valid <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (base_addr[5:0] != 6'd0) begin
                            r_error <= 1'b1;
                        end else if (num_lines == 32'd0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_busy      <= 1'b1;
                            r_base_cl   <= byteAddrToClAddr(base_addr);
                            r_num_lines <= num_lines;
                            r_issued    <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_issued <= r_issued + 32'd1;
                        if (w_last) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !rd_rsp_valid) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_req_hdr <= cci_mpf_c0_genReqHdr(eREQ_RDLINE_I,
                                              r_base_cl + t_cci_clAddr'(r_issued),
                                              r_issued[15:0], w_params);
        end
    end

    // Responses are forwarded even after a reset so late data is not lost.
    always_ff @(posedge clk) begin
        if (!reset_n) r_out_valid <= 1'b0;
        else          r_out_valid <= rd_rsp_valid;
    end

    always_ff @(posedge clk) begin
        if (rd_rsp_valid) begin
            r_out_data <= rd_rsp_data;
            r_out_idx  <= rd_rsp_mdata;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign rd_req_valid = r_req_valid;
    assign rd_req_hdr   = r_req_hdr;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_idx      = r_out_idx;

endmodule

// File: tb/tb_cl_read_issuer.sv
// Directed bench for cl_read_issuer with an in-order read responder.
module tb_cl_read_issuer;
    import afu_base::*;

    localparam int MAXO = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   start = 1'b0;
    t_byteAddr              base_addr = '0;
    logic [31:0]            num_lines = '0;
    logic                   busy, done, error;
    logic                   c0TxAlmFull = 1'b0;
    logic                   rd_req_valid;
    t_cci_mpf_c0_ReqMemHdr  rd_req_hdr;
    logic                   rd_rsp_valid = 1'b0;
    t_cci_mdata             rd_rsp_mdata = '0;
    logic [CACHE_WIDTH-1:0] rd_rsp_data = '0;
    logic                   out_valid;
    logic [CACHE_WIDTH-1:0] out_data;
    logic [15:0]            out_idx;

    cl_read_issuer #(
        .MAX_OUTSTANDING(MAXO),
        .ADDR_VIRTUAL   (1)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .c0TxAlmFull  (c0TxAlmFull),
        .rd_req_valid (rd_req_valid),
        .rd_req_hdr   (rd_req_hdr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_mdata (rd_rsp_mdata),
        .rd_rsp_data  (rd_rsp_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_idx      (out_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nreq = 0, nout = 0, ndone = 0, nerr = 0;
    bit rsp_en = 1'b0;
    t_cci_mdata  pend_q[$];
    t_cci_mdata  exp_q[$];
    t_cci_clAddr addr_log[$];
    t_cci_mdata  mdata_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CACHE_WIDTH-1:0] pat(input t_cci_mdata m);
        return {32{m ^ 16'h5A3C}};
    endfunction

    task automatic clear_logs();
        nreq = 0; nout = 0; ndone = 0; nerr = 0;
        addr_log.delete();
        mdata_log.delete();
    endtask

    task automatic do_start(input t_byteAddr a, input logic [31:0] n);
        @(posedge clk); #2;
        start = 1'b1; base_addr = a; num_lines = n;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 300 && !done; k++) @(negedge clk);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    // Monitor plus responder: records requests, checks forwarded lines and
    // returns one response per cycle in issue order while enabled.
    initial begin
        t_cci_mdata m;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                nout++;
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", {63'd0, out_valid}, 64'd0);
                end else begin
                    m = exp_q.pop_front();
                    chk("out_idx", {48'd0, out_idx}, {48'd0, m});
                    chk("out_data", {63'd0, out_data === pat(m)}, 64'd1);
                end
            end
            if (done)  ndone++;
            if (error) nerr++;
            if (rd_req_valid) begin
                nreq++;
                pend_q.push_back(rd_req_hdr.mdata);
                addr_log.push_back(rd_req_hdr.address);
                mdata_log.push_back(rd_req_hdr.mdata);
                chk("req_type", {60'd0, rd_req_hdr.req_type}, {60'd0, eREQ_RDLINE_I});
                chk("req_len", {62'd0, rd_req_hdr.cl_len}, {62'd0, eCL_LEN_1});
                chk("req_virt", {63'd0, rd_req_hdr.addrIsVirtual}, 64'd1);
            end
            if (rsp_en && pend_q.size() > 0) begin
                m = pend_q.pop_front();
                rd_rsp_valid = 1'b1;
                rd_rsp_mdata = m;
                rd_rsp_data  = pat(m);
                exp_q.push_back(m);
            end else begin
                rd_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_req_valid", {63'd0, rd_req_valid}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count", 64'(u_dut.u_credit.o_count), 64'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        // Four lines from 0x1000, immediate responses
        clear_logs();
        rsp_en = 1'b1;
        do_start(48'h1000, 32'd4);
        wait_done("t040");
        repeat (3) @(negedge clk);
        chk("t040_nreq", 64'(nreq), 64'd4);
        chk("t040_nout", 64'(nout), 64'd4);
        chk("t040_ndone", 64'(ndone), 64'd1);
        for (int i = 0; i < addr_log.size(); i++) begin
            chk("t040_addr", 64'(addr_log[i]), 64'h40 + 64'(i));
            chk("t040_mdata", 64'(mdata_log[i]), 64'(i));
        end

        // Misaligned base is rejected
        clear_logs();
        do_start(48'h1004, 32'd5);
        @(negedge clk);
        chk("t041_error", {63'd0, error}, 64'd1);
        chk("t041_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("t041_error_clr", {63'd0, error}, 64'd0);
        repeat (3) @(negedge clk);
        chk("t041_nreq", 64'(nreq), 64'd0);
        chk("t041_nerr", 64'(nerr), 64'd1);
        chk("t041_busy_end", {63'd0, busy}, 64'd0);

        // Zero lines completes without requests
        clear_logs();
        do_start(48'h2000, 32'd0);
        @(negedge clk);
        chk("t042_done_early", {63'd0, done}, 64'd0);
        chk("t042_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("t042_done", {63'd0, done}, 64'd1);
        chk("t042_busy_clr", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        chk("t042_nreq", 64'(nreq), 64'd0);
        chk("t042_ndone", 64'(ndone), 64'd1);

        // Credit limit with withheld responses
        clear_logs();
        rsp_en = 1'b0;
        do_start(48'h4000, 32'd10);
        repeat (8) @(negedge clk);
        chk("t043_nreq_stall", 64'(nreq), 64'd4);
        chk("t043_count_full", 64'(u_dut.u_credit.o_count), 64'd4);
        chk("t043_busy", {63'd0, busy}, 64'd1);
        do_start(48'h8000, 32'd2);
        repeat (2) @(negedge clk);
        chk("t043_start_ignored", 64'(nreq), 64'd4);
        @(posedge clk); #2;
        rsp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t043_count_dec", 64'(u_dut.u_credit.o_count), 64'd3);
        @(negedge clk);
        chk("t043_count_same", 64'(u_dut.u_credit.o_count), 64'd3);
        wait_done("t043");
        repeat (3) @(negedge clk);
        chk("t043_nreq", 64'(nreq), 64'd10);
        chk("t043_nout", 64'(nout), 64'd10);
        chk("t043_ndone", 64'(ndone), 64'd1);
        for (int i = 0; i < mdata_log.size(); i++) begin
            chk("t043_addr", 64'(addr_log[i]), 64'h100 + 64'(i));
            chk("t043_mdata", 64'(mdata_log[i]), 64'(i));
        end

        // Almost-full back-pressure mid-transfer
        clear_logs();
        do_start(48'h10000, 32'd8);
        @(posedge clk); #2;
        c0TxAlmFull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t044_no_req", {63'd0, rd_req_valid}, 64'd0);
        end
        c0TxAlmFull = 1'b0;
        wait_done("t044");
        repeat (3) @(negedge clk);
        chk("t044_nreq", 64'(nreq), 64'd8);
        chk("t044_nout", 64'(nout), 64'd8);
        for (int i = 0; i < mdata_log.size(); i++)
            chk("t044_mdata", 64'(mdata_log[i]), 64'(i));

        // Reset during drain; late responses forwarded, counter pinned at 0
        clear_logs();
        rsp_en = 1'b0;
        do_start(48'h20000, 32'd3);
        repeat (4) @(negedge clk);
        chk("t045_state_drain", 64'(u_dut.r_state), 64'(ST_DRAIN));
        chk("t045_count3", 64'(u_dut.u_credit.o_count), 64'd3);
        chk("t045_nreq", 64'(nreq), 64'd3);
        @(posedge clk); #2;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("t045_state_idle", 64'(u_dut.r_state), 64'(ST_IDLE));
        chk("t045_busy", {63'd0, busy}, 64'd0);
        chk("t045_req_valid", {63'd0, rd_req_valid}, 64'd0);
        chk("t045_count_rst", 64'(u_dut.u_credit.o_count), 64'd0);
        #1;
        reset_n = 1'b1;
        rsp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t045_count_sat", 64'(u_dut.u_credit.o_count), 64'd0);
        end
        chk("t045_nout", 64'(nout), 64'd3);
        chk("t045_ndone", 64'(ndone), 64'd0);
        chk("t045_busy_end", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
